// File: rtl/presorter_ctrl.sv
// Valid/ready wrapper around the fixed-latency presorter pipeline.
// Tags each beat through the pipeline and catches results in a credit-protected FWFT FIFO.
module presorter_ctrl #(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int PIPE_LATENCY   = 6,
    parameter int OUT_FIFO_DEPTH = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AXI_DATA_WIDTH-1:0] in_data,
    input  logic                      in_last,
    output logic [AXI_DATA_WIDTH-1:0] sort_in_data,
    input  logic [AXI_DATA_WIDTH-1:0] sort_out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AXI_DATA_WIDTH-1:0] out_data,
    output logic                      out_last,
    output logic                      idle,
    output logic [31:0]               beat_count
);
    localparam int PW = $clog2(OUT_FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [PIPE_LATENCY-1:0] vld_sr, last_sr;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count, credit, credit_next;
    logic [AXI_DATA_WIDTH:0] mem [OUT_FIFO_DEPTH];
    logic [AXI_DATA_WIDTH:0] head;
    logic                    accept, pop, wr_en;

    assign sort_in_data = in_data;
    assign accept       = in_valid & in_ready;
    assign out_valid    = (count != '0);
    assign pop          = out_valid & out_ready;
    assign wr_en        = vld_sr[PIPE_LATENCY-1];
    assign head         = mem[rd_ptr];
    assign out_data     = head[AXI_DATA_WIDTH-1:0];
    // Gate with out_valid so out_last reads 0 while the unreset memory is stale.
    assign out_last     = out_valid & head[AXI_DATA_WIDTH];
    assign idle         = (vld_sr == '0) & (count == '0);

    // Credits cover both FIFO occupancy and beats still inside the presorter.
    always_comb begin
        credit_next = credit;
        case ({accept, pop})
            2'b10:   credit_next = credit - CW'(1);
            2'b01:   credit_next = credit + CW'(1);
            default: credit_next = credit;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= accept;
            last_sr[0] <= in_last;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            credit   <= CW'(OUT_FIFO_DEPTH);
            in_ready <= 1'b0;
        end else begin
            credit   <= credit_next;
            in_ready <= (credit_next != '0);
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= {last_sr[PIPE_LATENCY-1], sort_out_data};
    end

    // No full check on the write side: the credit counter already guarantees space.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                beat_count <= beat_count + 32'd1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_presorter_ctrl.sv
// Directed bench for presorter_ctrl with a behavioural 8-lane sorting pipeline model.
module tb_presorter_ctrl;
    localparam int W = 512;
    localparam int L = 6;
    localparam int D = 16;

    logic         aclk, areset, in_valid, in_ready, in_last;
    logic [W-1:0] in_data, sort_in_data, sort_out_data, out_data;
    logic         out_valid, out_ready, out_last, idle;
    logic [31:0]  beat_count;

    presorter_ctrl #(.AXI_DATA_WIDTH(W), .PIPE_LATENCY(L), .OUT_FIFO_DEPTH(D)) dut (
        .aclk(aclk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .sort_in_data(sort_in_data),
        .sort_out_data(sort_out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .idle(idle), .beat_count(beat_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [W-1:0] sort8(input logic [W-1:0] d);
        logic [63:0]  a [8];
        logic [63:0]  t;
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) a[i] = d[i*64 +: 64];
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        for (int i = 0; i < 8; i++) r[i*64 +: 64] = a[i];
        return r;
    endfunction

    function automatic logic is_asc(input logic [W-1:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 7; i++) if (d[i*64 +: 64] > d[(i+1)*64 +: 64]) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [W-1:0] rnd512();
        logic [W-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Presorter model: free-running, sorts at stage 0, no reset.
    logic [W-1:0] ps [L];
    always @(posedge aclk) begin
        ps[0] <= sort8(sort_in_data);
        for (int i = 1; i < L; i++) ps[i] <= ps[i-1];
    end
    assign sort_out_data = ps[L-1];

    int checks = 0, failures = 0;
    int cyc = 0, n_acc = 0, n_pop = 0, stalls = 0, first_pop = -1, last_pop = -1;
    logic         offer, cur_last, s_in_ready, s_out_valid, s_idle;
    logic [W-1:0] cur_data;
    logic [W:0]   q [$];

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic new_beat();
        cur_data = rnd512();
        cur_last = 1'($urandom_range(0, 1));
    endtask

    // One cycle: drive after the edge, sample on the falling edge, score accept/pop.
    task automatic tick();
        logic [W:0] e;
        in_valid = offer;
        in_data  = offer ? cur_data : rnd512();
        in_last  = offer ? cur_last : 1'($urandom_range(0, 1));
        @(negedge aclk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_idle      = idle;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("stale_beat", 1, 0);
            else begin
                e = q.pop_front();
                chk("data", {1'b0, out_data}, {1'b0, e[W-1:0]});
                chk("last", W'(out_last), W'(e[W]));
                chk("ascending", W'(is_asc(out_data)), 1);
            end
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (in_valid && in_ready) begin
            q.push_back({cur_last, sort8(cur_data)});
            n_acc++;
            new_beat();
        end
        if (in_valid && !in_ready) stalls++;
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int k;
        offer = 1'b0;
        out_ready = 1'b1;
        for (k = 0; k < 100 && (q.size() != 0 || !idle); k++) tick();
        chk("drain_empty", q.size(), 0);
        tick();
        chk("drain_idle", W'(s_idle), 1);
        chk("beat_count", beat_count, n_pop);
    endtask

    initial begin
        int a0, st0, p0, k;
        areset = 1'b1; offer = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        new_beat();
        #3;
        chk("rst_in_ready", W'(in_ready), 0);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_out_last", W'(out_last), 0);
        chk("rst_idle", W'(idle), 1);
        chk("rst_beat_count", beat_count, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        #2;
        chk("release_in_ready_low", W'(in_ready), 0);
        @(posedge aclk); #1;
        chk("first_edge_in_ready", W'(in_ready), 1);

        // Single beat latency and idle.
        offer = 1'b1; cur_last = 1'b1;
        tick();
        chk("single_acc", n_acc, 1);
        offer = 1'b0;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (s_out_valid) break;
            chk("single_idle_busy", W'(s_idle), 0);
        end
        chk("single_latency", k, L + 1);
        tick();
        chk("single_idle_after", W'(s_idle), 1);
        chk("single_beat_count", beat_count, 1);

        // Streaming 100 beats.
        drain();
        a0 = n_acc; st0 = stalls; p0 = n_pop; first_pop = -1;
        offer = 1'b1;
        repeat (100) tick();
        chk("stream_acc", n_acc - a0, 100);
        chk("stream_stalls", stalls - st0, 0);
        drain();
        chk("stream_pops", n_pop - p0, 100);
        chk("stream_contig", last_pop - first_pop, 99);

        // Backpressure: 20 offered, 16 fit.
        a0 = n_acc;
        out_ready = 1'b0; offer = 1'b1;
        repeat (30) tick();
        chk("bp_accepted", n_acc - a0, D);
        chk("bp_in_ready_low", W'(s_in_ready), 0);
        chk("bp_out_valid", W'(s_out_valid), 1);
        out_ready = 1'b1;
        for (k = 0; k < 50 && (n_acc - a0) < 20; k++) tick();
        chk("bp_all_20", n_acc - a0, 20);
        drain();

        // Hold credit at 1 with simultaneous accept and pop.
        a0 = n_acc;
        out_ready = 1'b0; offer = 1'b1;
        for (k = 0; k < 30 && (n_acc - a0) < D - 1; k++) tick();
        offer = 1'b0;
        repeat (8) tick();
        chk("c1_in_ready", W'(s_in_ready), 1);
        a0 = n_acc; st0 = stalls;
        out_ready = 1'b1; offer = 1'b1;
        repeat (50) tick();
        chk("c1_acc", n_acc - a0, 50);
        chk("c1_stalls", stalls - st0, 0);
        chk("c1_in_ready_end", W'(s_in_ready), 1);
        drain();

        // Reset with 3 beats buffered and 5 in the pipe.
        out_ready = 1'b0; offer = 1'b1;
        repeat (3) tick();
        offer = 1'b0;
        tick();
        offer = 1'b1;
        repeat (5) tick();
        chk("mid_out_valid_pre", W'(out_valid), 1);
        areset = 1'b1;
        #1;
        chk("mid_out_valid", W'(out_valid), 0);
        chk("mid_idle", W'(idle), 1);
        chk("mid_beat_count", beat_count, 0);
        chk("mid_in_ready", W'(in_ready), 0);
        q.delete(); n_pop = 0;
        offer = 1'b0; in_valid = 1'b0;
        @(posedge aclk); @(posedge aclk); #1;
        areset = 1'b0;
        out_ready = 1'b1;
        repeat (15) tick();
        chk("mid_no_stale", n_pop, 0);
        chk("mid_idle_after", W'(s_idle), 1);

        // Random bubbles and backpressure.
        a0 = n_acc; p0 = n_pop;
        repeat (200) begin
            offer = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        chk("bubble_count", n_pop - p0, n_acc - a0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got running want finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
